// File: rtl/main_memory_ctl.sv
// main_memory_ctl
//   Single-port word memory behind a valid/ready request channel and a
//   registered response channel with backpressure. One outstanding request
//   at a time, a configurable number of wait states between accept and
//   access, per-byte write masking and out-of-range address detection.
//
// Optional feature (compile-time macro MAIN_MEMORY_CTL_CLEAR_EN):
//   when defined, every reset release starts a sweep that writes 0 to words
//   0..len-1, one per clock, with req_ready held low until it completes.
//
// Parameters:
//   word_size    data word width in bits (multiple of 8)
//   len          number of implemented words
//   len_log_2    address width, 2**len_log_2 >= len
//   wait_states  extra cycles between accept and memory access (0..15)
//   lanes        byte lanes per word (derived from word_size)
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-high reset
//   req_valid   request present
//   req_ready   block can accept a request (IDLE)
//   req_write   1 = write, 0 = read
//   req_addr    word address
//   req_wdata   write data
//   req_wmask   byte-lane write enables, bit i covers bits [8i+7:8i]
//   resp_valid  response present
//   resp_ready  consumer accepts the response
//   resp_rdata  read data, 0 for writes and errors
//   resp_err    address was >= len
module main_memory_ctl #(
  parameter int word_size   = 32,
  parameter int len         = 65000,
  parameter int len_log_2   = 16,
  parameter int wait_states = 2,
  parameter int lanes       = word_size / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [len_log_2-1:0] req_addr,
  input  logic [word_size-1:0] req_wdata,
  input  logic [lanes-1:0]     req_wmask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [word_size-1:0] resp_rdata,
  output logic                 resp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_RESP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'((wait_states == 0) ? 0 : wait_states - 1);

  logic [word_size-1:0] mem [0:len-1];

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic                 load;
  logic                 acc_en;

  logic                 lat_write;
  logic [len_log_2-1:0] lat_addr;
  logic [word_size-1:0] lat_wdata;
  logic [lanes-1:0]     lat_wmask;

  logic                 acc_write;
  logic [len_log_2-1:0] acc_addr;
  logic [word_size-1:0] acc_wdata;
  logic [lanes-1:0]     acc_wmask;
  logic                 in_range;
  logic                 wr_en;

`ifdef MAIN_MEMORY_CTL_CLEAR_EN
  localparam logic [len_log_2-1:0] CLR_LAST = len_log_2'(len - 1);
  logic [len_log_2-1:0] clr_addr;
`endif

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // With zero wait states the access happens on the accept edge itself, so
  // it must use the live request lines; otherwise the latched copy is used.
  always_comb begin
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_write = lat_write;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      acc_wmask = lat_wmask;
    end
  end

  assign in_range = (32'(acc_addr) < 32'(len));
  assign wr_en    = acc_en && acc_write && in_range && !reset;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    acc_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          load = 1'b1;
          if (wait_states == 0) begin
            acc_en    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          acc_en    = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      S_CLEAR: begin
`ifdef MAIN_MEMORY_CTL_CLEAR_EN
        if (clr_addr == CLR_LAST) state_nxt = S_IDLE;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef MAIN_MEMORY_CTL_CLEAR_EN
      state    <= S_CLEAR;
      clr_addr <= '0;
`else
      state    <= S_IDLE;
`endif
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wmask <= req_wmask;
      end
      if (acc_en) begin
        resp_err   <= !in_range;
        resp_rdata <= (!acc_write && in_range) ? mem[acc_addr] : '0;
      end
`ifdef MAIN_MEMORY_CTL_CLEAR_EN
      if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
`endif
    end
  end

  // Array storage has no reset; only the enables are qualified by reset so a
  // pending write is dropped when reset arrives before its access edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < lanes; i++) begin
        if (acc_wmask[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
`ifdef MAIN_MEMORY_CTL_CLEAR_EN
    if (state == S_CLEAR && !reset) mem[clr_addr] <= '0;
`endif
  end

endmodule

// File: tb/tb_main_memory_ctl.sv
module tb_main_memory_ctl;

  localparam int WS  = 2;
  localparam int LEN = 65000;
  localparam int AW  = 16;
  localparam int WW  = 32;
  localparam int LN  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_wdata;
  logic [LN-1:0] req_wmask;
  logic          resp_valid;
  logic          resp_ready;
  logic [WW-1:0] resp_rdata;
  logic          resp_err;

  main_memory_ctl #(
    .word_size  (WW),
    .len        (LEN),
    .len_log_2  (AW),
    .wait_states(WS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

`ifdef MAIN_MEMORY_CTL_CLEAR_EN
  localparam logic RST_READY = 1'b0;
`else
  localparam logic RST_READY = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout or unexpected event (t=%0t)", name, $time);
  endtask

  // Monitor: pops one expectation when a response appears and checks it is
  // held unchanged for as long as resp_valid stays high.
  always @(negedge clk) begin
    if (resp_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        cur = sb.pop_front();
        check("resp_rdata", resp_rdata, cur.rdata);
        check("resp_err", 32'(resp_err), 32'(cur.err));
        check("latency", cyc, cur.acc + WS);
      end
    end else if (resp_valid) begin
      check("hold_rdata", resp_rdata, cur.rdata);
      check("hold_err", 32'(resp_err), 32'(cur.err));
    end
    if (resp_valid) check("req_ready_in_resp", 32'(req_ready), 32'd0);
    prev_valid = resp_valid;
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d,
                       input logic [LN-1:0] m, input logic [WW-1:0] er, input logic ee);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail_now("req_ready_wait");
      return;
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    e.rdata = er;
    e.err   = ee;
    e.acc   = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble the request lines to show the latched copy is used.
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = ~a;
    req_wdata = ~d;
    req_wmask = ~m;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || resp_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0 || resp_valid) fail_now("drain");
  endtask

  task automatic wait_ready(input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) fail_now("ready_after_reset");
  endtask

  initial begin
    int k;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'(RST_READY));
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b0;
    wait_ready(70000);

    // Basic write then read
    issue(1'b1, 16'h0010, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 16'h0010, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0);

    // Byte masking, including an all-zero mask
    issue(1'b1, 16'd5, 32'h11223344, 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 16'd5, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    issue(1'b0, 16'd5, 32'h0,        4'b0000, 32'h11BB33DD, 1'b0);
    issue(1'b1, 16'd5, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
    issue(1'b0, 16'd5, 32'h0,        4'b0000, 32'h11BB33DD, 1'b0);
    issue(1'b1, 16'd5, 32'h99887766, 4'b1000, 32'h0, 1'b0);
    issue(1'b0, 16'd5, 32'h0,        4'b0000, 32'h99BB33DD, 1'b0);

    // Address range boundary
    issue(1'b1, 16'd64999, 32'h5A5A0001, 4'b1111, 32'h0, 1'b0);
    issue(1'b1, 16'd0,     32'h0BADCAFE, 4'b1111, 32'h0, 1'b0);
    issue(1'b0, 16'd65000, 32'h0,        4'b0000, 32'h0, 1'b1);
    issue(1'b1, 16'd65000, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
    issue(1'b0, 16'd65535, 32'h0,        4'b0000, 32'h0, 1'b1);
    issue(1'b0, 16'd64999, 32'h0,        4'b0000, 32'h5A5A0001, 1'b0);
    issue(1'b0, 16'd0,     32'h0,        4'b0000, 32'h0BADCAFE, 1'b0);

    // Response backpressure
    issue(1'b1, 16'd9, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
    drain();
    resp_ready = 1'b0;
    issue(1'b0, 16'd9, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0);
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!resp_valid) fail_now("bp_resp_valid");
    repeat (5) @(negedge clk);
    check("bp_resp_valid_held", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_release_resp_valid", 32'(resp_valid), 32'd0);

    // Reset during WAIT drops the pending write
    issue(1'b1, 16'd7, 32'h0, 4'b1111, 32'h0, 1'b0);
    drain();
    issue(1'b1, 16'd7, 32'h12345678, 4'b1111, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("wrst_req_ready", 32'(req_ready), 32'(RST_READY));
    check("wrst_resp_valid", 32'(resp_valid), 32'd0);
    check("wrst_resp_rdata", resp_rdata, 32'd0);
    check("wrst_resp_err", 32'(resp_err), 32'd0);
    if (sb.size() == 1) void'(sb.pop_back());
    else fail_now("wrst_scoreboard");
    @(negedge clk);
    reset = 1'b0;
    wait_ready(70000);
    issue(1'b0, 16'd7, 32'h0, 4'b0000, 32'h0, 1'b0);

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
